uart_tx: RTL
============

# uart_tx

Parametrised, buffered UART transmitter: the next generation of the fixed 8N1 transmitter used by the heartbeat demo. Generalises data width, parity and stop bits, and puts a FIFO in front of the shift engine so callers can burst several words without waiting for each frame. Sits between any on-chip producer and the external TXD pin, running in the single `clk` domain (12 MHz on the current board).

## Interface
- `CLK_HZ`, 12000000: frequency of `clk` in Hz.
- `BAUD_RATE`, 115200: line rate in bits/s.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: words buffered, power of two, at least 2.
- `clk`  in  1  system clock; the single clock for the block.
- `reset`  in  1  synchronous, active-high reset.
- `tx_data`  in  DATA_BITS  word to send; sampled when `tx_request` is high.
- `tx_request`  in  1  one-cycle write strobe into the FIFO.
- `tx_full`  out  1  FIFO holds FIFO_DEPTH words.
- `tx_busy`  out  1  a frame is on the line or the FIFO is non-empty.
- `tx_overrun`  out  1  one-cycle pulse: request dropped because FIFO was full.
- `tx_line`  out  1  TXD; idles high.

## Operation
- DIVISOR = CLK_HZ / BAUD_RATE, rounded to nearest; 104 at the defaults. Every bit lasts exactly DIVISOR cycles.
- Frame, LSB first: start (0), DATA_BITS data, optional parity, STOP_BITS stop (1).
- Parity is computed over the data bits only. Odd: total ones in data plus parity is odd. Even: that total is even.
- FSM states are IDLE, START, DATA, PARITY, STOP. From IDLE the FSM pops and loads the shift register when the FIFO is non-empty, then goes to START.
- Transitions: START to DATA. DATA to PARITY after the last data bit when PARITY != 0, otherwise to STOP. PARITY to STOP. After the final stop bit, STOP goes to START if the FIFO is non-empty (pop in the same cycle), otherwise to IDLE.
- Bit counter and baud counter reset at every state change.
- Write rule: a request with `tx_full` low pushes the word. A request with `tx_full` high is dropped and pulses `tx_overrun` on the next cycle.
- `tx_full` is evaluated on the pre-edge count. A request while full is dropped even if a pop happens in the same cycle.
- A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Reset values: `tx_line`=1, `tx_full`=0, `tx_busy`=0, `tx_overrun`=0, FIFO empty, FSM in IDLE.
- Reset mid-frame abandons the frame. `tx_line` is high after the reset edge and the FIFO contents are discarded.

## Timing
- `tx_line` is driven from a register and never glitches within a bit.
- Latency: a request sampled at edge E0 with the FIFO empty and the FSM idle puts the word in the FIFO. The FSM pops at E1, and `tx_line` goes low from E1 onward.
- Frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × DIVISOR cycles; 1040 for 8N1 at the defaults.
- Back-to-back frames have no idle gap: the next start bit follows the last stop-bit cycle directly.
- `tx_busy` rises at the edge after an accepted push. It falls at the edge ending the last stop bit of the last queued word.
- `tx_full` rises at the edge of the push that fills the FIFO and falls at the edge of the next pop.

## Structure
- Shared package `uart_pkg` holds:
  - parity-mode constants (PARITY_NONE/ODD/EVEN);
  - FSM state encoding;
  - a constant function computing DIVISOR and the counter widths.
- The FIFO is a natural sub-module, `sync_fifo`, parametrised on WIDTH and DEPTH. It has push/pop, full/empty and registered pointers, with wrap-around via an extra pointer bit.
- The transmit FSM, baud counter and shift register stay in `uart_tx`.

## Test plan
- Defaults, request 0x2E once. Expect `tx_line` low from 1 cycle after the sample edge, then bits 0,1,1,1,0,1,0,0, then 1 stop; each bit lasts 104 cycles; `tx_busy` is high for 1040 cycles.
- PARITY=1, then PARITY=2, send 0x2E. Expect parity bit 1 (odd), then 0 (even); frame is 1144 cycles.
- DATA_BITS=7, STOP_BITS=2, send 0x41. Expect data 1,0,0,0,0,0,1 and two 104-cycle stop bits.
- FIFO_DEPTH=4, six requests in consecutive cycles (0x30..0x35) while idle:
  - the first is popped immediately, so the next four fill the FIFO and `tx_full` rises;
  - the sixth is dropped with one `tx_overrun` pulse;
  - 0x30..0x34 are sent with no inter-frame gap.
- Assert `reset` for one cycle mid-DATA of a frame with 2 words queued. Expect `tx_line`=1 after the edge, all status outputs 0, and no further frames.
- Request while full in the same cycle as the FSM pops. Expect the request dropped, `tx_overrun` pulsed, and the count to drop by one.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity modes, FSM
// state encoding and the compile-time helpers that size the counters.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_t;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int calc_divisor(input int clk_hz, input int baud_rate);
    return (clk_hz + baud_rate / 2) / baud_rate;
  endfunction

  // Width of a counter that runs 0 .. max_count-1.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO with registered pointers; the extra pointer MSB
// distinguishes full from empty when the address bits match.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // Full is judged on the pre-edge count, so a write while full is lost
  // even if a pop frees a slot on the same edge.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which words are valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: FIFO in front of a start/data/parity/stop
// shift engine, TXD driven straight from a register.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_request,
  output logic                 tx_full,
  output logic                 tx_busy,
  output logic                 tx_overrun,
  output logic                 tx_line
);

  localparam int DIVISOR = calc_divisor(CLK_HZ, BAUD_RATE);
  localparam int BAUD_W  = cnt_width(DIVISOR);
  localparam int BIT_W   = cnt_width(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(DIVISOR - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST     = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST     = BIT_W'(STOP_BITS - 1);
  localparam logic              PARITY_INVERT = (PARITY == PARITY_ODD);

  tx_state_t            r_state;
  tx_state_t            w_state_next;
  logic [BAUD_W-1:0]    r_baud_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [BIT_W-1:0]     w_bit_cnt_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 r_parity;
  logic                 w_parity_next;
  logic                 r_line;
  logic                 w_line_next;
  logic                 r_overrun;
  logic                 w_bit_end;
  logic                 w_fifo_pop;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [DATA_BITS-1:0] w_fifo_data;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (tx_request),
    .i_pop   (w_fifo_pop),
    .i_data  (tx_data),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_bit_end = (r_baud_cnt == BAUD_LAST);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    w_parity_next  = r_parity;
    w_fifo_pop     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_fifo_pop   = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == DATA_LAST) begin
            w_state_next = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
            w_shift_next   = r_shift >> 1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_bit_cnt != STOP_LAST) begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end else if (!w_fifo_empty) begin
            w_fifo_pop   = 1'b1;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_fifo_pop) begin
      w_shift_next  = w_fifo_data;
      w_parity_next = (^w_fifo_data) ^ PARITY_INVERT;
    end
    if (w_state_next != r_state) w_bit_cnt_next = '0;

    // Line level for the coming cycle, so TXD leaves a flop with no decode after it.
    w_line_next = 1'b1;
    case (w_state_next)
      S_START:  w_line_next = 1'b0;
      S_DATA:   w_line_next = w_shift_next[0];
      S_PARITY: w_line_next = w_parity_next;
      default:  w_line_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_line     <= 1'b1;
      r_overrun  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift   <= w_shift_next;
      r_parity  <= w_parity_next;
      r_line    <= w_line_next;
      r_overrun <= tx_request && w_fifo_full;
      if (r_state == S_IDLE || w_bit_end || w_state_next != r_state) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end
    end
  end

  assign tx_line    = r_line;
  assign tx_full    = w_fifo_full;
  assign tx_busy    = (r_state != S_IDLE);
  assign tx_overrun = r_overrun;

endmodule
